imm_decode_ctrl: RTL and testbench

//  ID-stage immediate controller for the pipelined RV32I core.
//  - Classifies each decoded instruction and generates the one-hot extender op.
//  - Forms the 32-bit immediate and queues {pc, instr, extop, imm} in a 2-entry skid buffer.
//  - The buffer drives the ID/EX boundary through a valid/ready handshake.
//  - Decouples fetch/decode from EX back-pressure and applies pipeline flushes.

---
 rtl/imm_decode_ctrl.sv | 153 +++++++++++++++
 tb/tb_imm_decode_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_ctrl.sv
// ID-stage immediate decoder feeding a 2-entry skid buffer toward EX.
// Optional macro IMM_ILLEGAL_CHK_EN stores a per-entry illegal-opcode flag.
module imm_decode_ctrl #(
  parameter int PC_W    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [5:0]      out_extop,
  output logic [31:0]     out_imm,
  output logic            out_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [5:0]      extop;
    logic [31:0]     imm;
`ifdef IMM_ILLEGAL_CHK_EN
    logic            illegal;
`endif
  } entry_t;

  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I     = 6'b010000;
  localparam logic [5:0] EXT_S     = 6'b001000;
  localparam logic [5:0] EXT_B     = 6'b000100;
  localparam logic [5:0] EXT_U     = 6'b000010;
  localparam logic [5:0] EXT_J     = 6'b000001;

  state_t state;
  entry_t head, skid, dec;
  logic   push, pop;

  // Decode once on the way in; the buffer only ever moves finished entries.
  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.instr = in_instr;
    unique case (in_instr[6:0])
      7'b0010011: begin
        if (in_instr[13:12] == 2'b01) begin
          dec.extop = EXT_SHAMT;
          dec.imm   = {{(32-SHAMT_W){1'b0}}, in_instr[20 +: SHAMT_W]};
        end else begin
          dec.extop = EXT_I;
          dec.imm   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0000011, 7'b1100111: begin
        dec.extop = EXT_I;
        dec.imm   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec.extop = EXT_S;
        dec.imm   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.extop = EXT_B;
        dec.imm   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.extop = EXT_U;
        dec.imm   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.extop = EXT_J;
        dec.imm   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011: ;
      default: begin
`ifdef IMM_ILLEGAL_CHK_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      head      <= '0;
      skid      <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head      <= dec;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= dec;
          end else if (push) begin
            skid     <= dec;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            head     <= skid;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign out_extop = head.extop;
  assign out_imm   = head.imm;
`ifdef IMM_ILLEGAL_CHK_EN
  assign out_illegal = head.illegal;
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Randomised bench for imm_decode_ctrl with a queue-based reference model
// and a set of literal decode/handshake expectations.
module tb_imm_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_instr, out_pc, out_imm;
  logic [5:0]  out_extop;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  extop;
    logic [31:0] imm;
    logic        illegal;
  } ent_t;

  ent_t q[$];

  imm_decode_ctrl #(.PC_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_extop(out_extop), .out_imm(out_imm),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference decode: fields placed at the top of a signed word and shifted down.
  function automatic ent_t model_decode(input logic [31:0] i, input logic [31:0] pc);
    ent_t e;
    logic signed [31:0] t;
    e.pc = pc; e.instr = i; e.extop = 6'b0; e.imm = 32'b0; e.illegal = 1'b0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: begin
        if (i[6:0] == 7'h13 && (i[14:12] == 3'd1 || i[14:12] == 3'd5)) begin
          e.extop = 6'b100000; e.imm = 32'(i[24:20]);
        end else begin
          t = i; e.extop = 6'b010000; e.imm = t >>> 20;
        end
      end
      7'h23: begin t = {i[31:25], i[11:7], 20'b0}; e.extop = 6'b001000; e.imm = t >>> 20; end
      7'h63: begin
        t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0};
        e.extop = 6'b000100; e.imm = t >>> 19;
      end
      7'h37, 7'h17: begin e.extop = 6'b000010; e.imm = i & 32'hFFFF_F000; end
      7'h6F: begin
        t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0};
        e.extop = 6'b000001; e.imm = t >>> 11;
      end
      7'h33: ;
      default: begin
`ifdef IMM_ILLEGAL_CHK_EN
        e.illegal = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  always @(posedge clk) begin
    bit can_push, do_pop;
    if (rst || flush) begin
      q.delete();
    end else begin
      can_push = (q.size() < 2);
      do_pop   = (q.size() > 0) && out_ready;
      if (do_pop) void'(q.pop_front());
      if (in_valid && can_push) q.push_back(model_decode(in_instr, in_pc));
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_out_valid", out_valid, q.size() != 0);
      chk("m_in_ready", in_ready, q.size() < 2);
      if (q.size() != 0) begin
        chk("m_instr", out_instr, q[0].instr);
        chk("m_pc", out_pc, q[0].pc);
        chk("m_extop", out_extop, q[0].extop);
        chk("m_imm", out_imm, q[0].imm);
        chk("m_illegal", out_illegal, q[0].illegal);
      end
    end
  end

  task automatic send_check(input string nm, input logic [31:0] ins,
                            input logic [5:0] eext, input logic [31:0] eimm);
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins; in_pc = $urandom; out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_extop"}, out_extop, eext);
    chk({nm, "_imm"}, out_imm, eimm);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops[10];
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
    r = $urandom;
    if ($urandom_range(0, 9) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_imm", out_imm, 32'h0);
    cmp_en = 1'b1;
    @(negedge clk) rst = 1'b0;

    send_check("addi", 32'hFFF00093, 6'b010000, 32'hFFFFFFFF);
    send_check("slli", 32'h00301093, 6'b100000, 32'h3);
    send_check("srai", 32'h4050D093, 6'b100000, 32'h5);
    send_check("beq",  32'hFE000EE3, 6'b000100, 32'hFFFFFFFC);
    send_check("jal",  32'hFF9FF06F, 6'b000001, 32'hFFFFFFF8);
    send_check("lui",  32'h123450B7, 6'b000010, 32'h12345000);
    send_check("sw",   32'h00112223, 6'b001000, 32'h4);
    send_check("add",  32'h002081B3, 6'b000000, 32'h0);
`ifdef IMM_ILLEGAL_CHK_EN
    send_check("illop", 32'h0000007F, 6'b000000, 32'h0);
    chk("illop_flag", out_illegal, 1'b1);
`endif

    // Back-pressure: A and B fill the buffer, C waits until space opens.
    @(negedge clk) in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00A00093;
    @(negedge clk) in_instr = 32'h00B00093;
    @(negedge clk) in_instr = 32'h00C00093;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_head_a", out_instr, 32'h00A00093);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_head_b", out_instr, 32'h00B00093);
    @(negedge clk);
    chk("bp_head_c", out_instr, 32'h00C00093);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drained", out_valid, 1'b0);

    // Flush with a full buffer and a pending input.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
    repeat (2) @(negedge clk);
    flush = 1'b1; in_instr = 32'h00200093;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);

    // Reset while full clears every output field.
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h1234;
    repeat (2) @(negedge clk);
    chk("full_before_rst", in_ready, 1'b0);
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rst2_out_valid", out_valid, 1'b0);
    chk("rst2_in_ready", in_ready, 1'b1);
    chk("rst2_fields", {out_instr, out_imm}, 64'h0);
    chk("rst2_misc", {out_pc, out_extop, out_illegal}, 39'h0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
